pc_sequencer: RTL and testbench

Parametrised program-counter sequencer that replaces the fixed jump/increment PC in the fetch stage. It adds stall, PC-relative branch, register-indirect jump, and call/return through an internal circular return-address stack (RAS). It drives the instruction-memory address and the link value consumed by the register-file write path.

---
 rtl/pc_sequencer_pkg.sv | 18 +
 rtl/pc_sequencer_ras_stack.sv | 57 +++++
 rtl/pc_sequencer.sv | 126 ++++++++++++
 tb/tb_pc_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

  // Winning next-PC source, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    SRC_RESET,
    SRC_HOLD,
    SRC_RET,
    SRC_JR,
    SRC_JUMP,
    SRC_BRANCH,
    SRC_SEQ
  } pc_src_t;

  // Byte distance between consecutive instruction words.
  localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack. Pushing onto a full stack overwrites the
// oldest entry. The count saturates at DEPTH. Popping an empty stack changes
// nothing. Entry storage has no reset; only the pointer and count do.
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW:0]      count_q, count_d;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  // ptr_q addresses the next free slot, so the newest entry sits one below it.
  assign top   = mem_q[ptr_q - AW'(1)];

  // Next pointer/count: push wins over pop; an empty pop is a no-op.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (reset) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (push) begin
      ptr_d = ptr_q + AW'(1);
      if (!full) count_d = count_q + (AW+1)'(1);
    end else if (pop && !empty) begin
      ptr_d   = ptr_q - AW'(1);
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    ptr_q   <= ptr_d;
    count_q <= count_d;
  end

  // Entry write at the current free slot.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: stall, PC-relative branch, absolute jump,
// register-indirect jump and call/return through a return-address stack.
// The return-address stack is built only when PC_SEQUENCER_RAS_EN is
// defined. Without it, ret and call are ignored and the RAS outputs read 0.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter int              OP_W      = 6,
  parameter int              RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        branch,
  input  logic [15:0]                 branch_off,
  input  logic                        jump,
  input  logic [WIDTH-OP_W-1:0]       jump_imm,
  input  logic                        jr,
  input  logic [WIDTH-1:0]            jr_addr,
  input  logic                        call,
  input  logic                        ret,
  output logic [WIDTH-1:0]            pc,
  output logic [WIDTH-1:0]            pc_plus4,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_overflow,
  output logic                        ras_underflow,
  output logic                        misalign
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  pc_src_t                  src;
  logic [WIDTH-1:0]         pc_q, pc_d;
  logic signed [WIDTH-1:0]  br_off_ext;
  logic [WIDTH-1:0]         ras_top;
  logic [CW-1:0]            ras_cnt;
  logic                     ras_push, ras_full, ras_empty, ret_en;
  logic                     ovf_q, ovf_d, unf_q, unf_d, mis_q, mis_d;

  assign pc_plus4 = pc_q + WIDTH'(PC_STEP);

`ifdef PC_SEQUENCER_RAS_EN
  logic ras_pop;

  assign ret_en   = ret;
  // The link is pushed only when call qualifies a winning jr or jump.
  assign ras_push = call && ((src == SRC_JR) || (src == SRC_JUMP));
  assign ras_pop  = (src == SRC_RET) && !ras_empty;

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .count     (ras_cnt),
    .full      (ras_full),
    .empty     (ras_empty)
  );
`else
  logic unused_ras_inputs;

  assign ret_en            = 1'b0;
  assign ras_push          = 1'b0;
  assign ras_top           = '0;
  assign ras_cnt           = '0;
  assign ras_full          = 1'b0;
  assign ras_empty         = 1'b1;
  assign unused_ras_inputs = call ^ ret;
`endif

  // Priority select of the next-PC source.
  always_comb begin
    src = SRC_SEQ;
    if (reset)       src = SRC_RESET;
    else if (stall)  src = SRC_HOLD;
    else if (ret_en) src = SRC_RET;
    else if (jr)     src = SRC_JR;
    else if (jump)   src = SRC_JUMP;
    else if (branch) src = SRC_BRANCH;
  end

  // Next-PC datapath and sticky-flag updates for the selected source.
  always_comb begin
    br_off_ext = WIDTH'($signed(branch_off));
    pc_d       = pc_plus4;
    unique case (src)
      SRC_RESET:  pc_d = RESET_VEC;
      SRC_HOLD:   pc_d = pc_q;
      SRC_RET:    pc_d = ras_empty ? pc_plus4 : ras_top;
      SRC_JR:     pc_d = {jr_addr[WIDTH-1:2], 2'b00};
      SRC_JUMP:   pc_d = {pc_q[WIDTH-1:WIDTH-OP_W+2], jump_imm, 2'b00};
      SRC_BRANCH: pc_d = pc_plus4 + $unsigned(br_off_ext <<< 2);
      default:    pc_d = pc_plus4;
    endcase

    ovf_d = ovf_q | (ras_push && ras_full);
    unf_d = unf_q | ((src == SRC_RET) && ras_empty);
    mis_d = mis_q | ((src == SRC_JR) && (jr_addr[1:0] != 2'b00));
    if (reset) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
      mis_d = 1'b0;
    end
  end

  // PC and sticky-flag registers.
  always_ff @(posedge clk) begin
    pc_q  <= pc_d;
    ovf_q <= ovf_d;
    unf_q <= unf_d;
    mis_q <= mis_d;
  end

  assign pc            = pc_q;
  assign ras_count     = ras_cnt;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign misalign      = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a driver applies directed and random
// requests and queues the state expected after each edge, computed by a
// queue-based reference model. A monitor pops and compares after each edge.
module tb_pc_sequencer;
  localparam int DEPTH = 8;
`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  typedef struct {
    logic        reset, stall, branch;
    logic [15:0] off;
    logic        jump;
    logic [25:0] imm;
    logic        jr;
    logic [31:0] jra;
    logic        call, ret;
  } in_t;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  cnt;
    logic        ovf, unf, mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, branch = 1'b0, jump = 1'b0;
  logic        jr = 1'b0, call = 1'b0, ret = 1'b0;
  logic [15:0] branch_off = '0;
  logic [25:0] jump_imm = '0;
  logic [31:0] jr_addr = '0;
  logic [31:0] pc, pc_plus4;
  logic [3:0]  ras_count;
  logic        ras_overflow, ras_underflow, misalign;

  int n_vec = 0;
  int n_err = 0;
  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_unf, m_mis;

  pc_sequencer #(.WIDTH(32), .OP_W(6), .RAS_DEPTH(DEPTH), .RESET_VEC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch),
    .branch_off(branch_off), .jump(jump), .jump_imm(jump_imm), .jr(jr),
    .jr_addr(jr_addr), .call(call), .ret(ret), .pc(pc), .pc_plus4(pc_plus4),
    .ras_count(ras_count), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow), .misalign(misalign)
  );

  always #5 clk = ~clk;

  function automatic in_t idle();
    in_t s;
    s.reset = 0; s.stall = 0; s.branch = 0; s.off = '0; s.jump = 0;
    s.imm = '0; s.jr = 0; s.jra = '0; s.call = 0; s.ret = 0;
    return s;
  endfunction

  function automatic in_t rnd();
    in_t s;
    s.reset  = ($urandom_range(63) == 0);
    s.stall  = ($urandom_range(7) == 0);
    s.branch = ($urandom_range(3) == 0);
    s.off    = 16'($urandom);
    s.jump   = ($urandom_range(5) == 0);
    s.imm    = 26'($urandom);
    s.jr     = ($urandom_range(7) == 0);
    s.jra    = $urandom;
    s.call   = ($urandom_range(2) == 0);
    s.ret    = ($urandom_range(4) == 0);
    return s;
  endfunction

  // Drive one request at the falling edge and queue the expected result.
  task automatic step(input in_t s);
    logic [31:0] link;
    exp_t e;
    @(negedge clk);
    reset = s.reset; stall = s.stall; branch = s.branch; branch_off = s.off;
    jump = s.jump; jump_imm = s.imm; jr = s.jr; jr_addr = s.jra;
    call = s.call; ret = s.ret;
    link = m_pc + 32'd4;
    if (s.reset) begin
      m_pc = 32'h0; m_ras.delete(); m_ovf = 0; m_unf = 0; m_mis = 0;
    end else if (s.stall) begin
      m_pc = m_pc;
    end else if (RAS_EN && s.ret) begin
      if (m_ras.size() == 0) begin
        m_pc = link; m_unf = 1;
      end else begin
        m_pc = m_ras.pop_back();
      end
    end else if (s.jr || s.jump) begin
      if (s.jr) begin
        m_pc = s.jra & 32'hFFFF_FFFC;
        if (s.jra[1:0] != 2'b00) m_mis = 1;
      end else begin
        m_pc = (m_pc & 32'hF000_0000) | (32'(s.imm) * 32'd4);
      end
      if (RAS_EN && s.call) begin
        m_ras.push_back(link);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1;
        end
      end
    end else if (s.branch) begin
      m_pc = link + 32'(int'($signed(s.off)) * 4);
    end else begin
      m_pc = link;
    end
    e.pc = m_pc; e.cnt = 4'(m_ras.size());
    e.ovf = m_ovf; e.unf = m_unf; e.mis = m_mis;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT state just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        chk("ras_count", 32'(ras_count), 32'(e.cnt));
        chk("ras_overflow", 32'(ras_overflow), 32'(e.ovf));
        chk("ras_underflow", 32'(ras_underflow), 32'(e.unf));
        chk("misalign", 32'(misalign), 32'(e.mis));
      end
    end
  end

  initial begin
    in_t s;
    m_pc = '0; m_ovf = 0; m_unf = 0; m_mis = 0;

    // Reset, then three sequential steps
    s = idle(); s.reset = 1; step(s);
    repeat (3) step(idle());

    // Branches from 0x100
    s = idle(); s.jr = 1; s.jra = 32'h100; step(s);
    s = idle(); s.branch = 1; s.off = 16'hFFFE; step(s);
    s = idle(); s.jr = 1; s.jra = 32'h100; step(s);
    s = idle(); s.branch = 1; s.off = 16'h0003; step(s);

    // Call then immediate return
    s = idle(); s.jr = 1; s.jra = 32'h1000_0040; step(s);
    s = idle(); s.jump = 1; s.call = 1; s.imm = 26'h200; step(s);
    s = idle(); s.ret = 1; step(s);

    // Nine calls into an 8-deep stack, then nine returns
    for (int i = 0; i < 9; i++) begin
      s = idle(); s.jump = 1; s.call = 1; s.imm = 26'(32'h40 * (i + 1)); step(s);
    end
    for (int i = 0; i < 9; i++) begin
      s = idle(); s.ret = 1; step(s);
    end

    // Stall holds everything, then a misaligned indirect jump
    s = idle(); s.stall = 1; s.jump = 1; s.call = 1; s.imm = 26'h33; step(s);
    step(s);
    s = idle(); s.jr = 1; s.jra = 32'h203; step(s);

    // Reset together with ret while three entries are stacked
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.jump = 1; s.call = 1; s.imm = 26'(32'h100 + i); step(s);
    end
    s = idle(); s.reset = 1; s.ret = 1; s.call = 1; step(s);

    // Randomised traffic
    for (int i = 0; i < 600; i++) step(rnd());
    step(idle());

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected results left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
